// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, write-first bypass,
// optional hard-wired zero register and a per-register pending-write scoreboard.

module regfile_mp_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  regs_nxt [DEPTH],
  input  logic [DEPTH-1:0]  busy_nxt,
  output logic [WIDTH-1:0]  data_q,
  output logic              busy_q
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  data_d;
  logic              busy_d;

  // Reading next-state contents gives write-first forwarding for free.
  always_comb begin
    hit    = ({1'b0, addr} < DEPTH_L) && !((ZERO_REG != 0) && (addr == '0));
    idx    = hit ? addr : '0;
    data_d = hit ? regs_nxt[idx] : '0;
    busy_d = hit && busy_nxt[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
endmodule

module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DEPTH*WIDTH-1:0]   dbg_regs
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_ok, iss_ok;

  always_comb begin
    wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_L) &&
             !((ZERO_REG != 0) && (wr_addr == '0));
    iss_ok = iss_en && ({1'b0, iss_addr} < DEPTH_L) &&
             !((ZERO_REG != 0) && (iss_addr == '0));
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Issue applied last so it wins over a same-cycle writeback.
    if (iss_ok) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_dbg
    assign dbg_regs[k*WIDTH +: WIDTH] = mem_q[k];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs_nxt (mem_d),
      .busy_nxt (busy_d),
      .data_q   (rd_data[i*WIDTH +: WIDTH]),
      .busy_q   (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver queues hand-computed read results,
// a negedge monitor pops and compares them against the registered read ports.

module tb_regfile_mp;
  localparam int W = 32, D = 32, AW = 5, NR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [W-1:0]     wr_data = '0;
  logic             iss_en = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic [D*W-1:0]   dbg_regs;

  typedef struct {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   busy;
  } exp_t;

  exp_t exp_q[$];
  logic chk_in = 1'b0;
  logic vld = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .dbg_regs(dbg_regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Response valid one cycle after a checked request
  always @(posedge clk) vld <= chk_in;

  always @(negedge clk) begin
    if (vld) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL underflow: response with empty expectation queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data0", rd_data[W-1:0], e.d0);
        check("rd_data1", rd_data[2*W-1:W], e.d1);
        check("rd_busy", {30'd0, rd_busy}, {30'd0, e.busy});
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic chk,
                       input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [1:0] eb);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr = {a1, a0}; chk_in = chk;
    if (chk) begin
      e.d0 = e0; e.d1 = e1; e.busy = eb;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic dbg_zero;
    // T1: reset cycle with write/issue that must be ignored; outputs 0 after edge
    drive(1, 1, 5, 32'hBAD0BAD0, 1, 5, 5, 5, 1, 0, 0, 2'b00);
    for (int i = 0; i < D/2; i++)
      drive(0, 0, 0, 0, 0, 0, AW'(2*i), AW'(2*i+1), 1, 0, 0, 2'b00);
    dbg_zero = (dbg_regs == '0);
    check("dbg_all_zero", {31'd0, dbg_zero}, 32'd1);

    // T2: write r5, read r5 on both ports next cycle
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    check("dbg_r5", dbg_regs[5*W +: W], 32'hDEADBEEF);

    // T3: r3=0x11, then write r7 with same-cycle read of r7 (bypass) and r3
    drive(0, 1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(0, 1, 7, 32'h12345678, 0, 0, 7, 3, 1, 32'h12345678, 32'h11, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 5, 7, 1, 32'hDEADBEEF, 32'h12345678, 2'b00);

    // T4: zero register ignores writes and issues
    drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    check("dbg_r0", dbg_regs[W-1:0], 32'h0);

    // T5: scoreboard set, issue beats writeback, writeback alone clears
    drive(0, 0, 0, 0, 1, 9, 9, 9, 1, 0, 0, 2'b11);
    drive(0, 1, 9, 32'hA5, 1, 9, 9, 9, 1, 32'hA5, 32'hA5, 2'b11);
    drive(0, 1, 9, 32'h5A, 0, 0, 9, 9, 1, 32'h5A, 32'h5A, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 9, 5, 1, 32'h5A, 32'hDEADBEEF, 2'b00);
    check("dbg_r9", dbg_regs[9*W +: W], 32'h5A);
    // busy is per port: only the port addressing the pending register sees it
    drive(0, 0, 0, 0, 1, 12, 5, 12, 1, 32'hDEADBEEF, 0, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 12, 5, 1, 0, 32'hDEADBEEF, 2'b01);

    // T6: issue+write r4, then reset with a write to r4 that must be lost
    drive(0, 1, 4, 32'h77, 1, 4, 4, 4, 1, 32'h77, 32'h77, 2'b11);
    drive(1, 1, 4, 32'h99, 0, 0, 4, 12, 1, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 4, 12, 1, 0, 0, 2'b00);
    check("dbg_r4", dbg_regs[4*W +: W], 32'h0);
    check("dbg_r5_after_rst", dbg_regs[5*W +: W], 32'h0);

    idle();
    idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
